// File: rtl/azadi_clkdiv_rstgen.sv
// -----------------------------------------------------------------------------
// azadi_clkdiv_rstgen
//   Multi-channel clock divider with per-channel reset stretcher.
//   Each channel counts 0..D-1 on the system clock and produces:
//     - clk_o  : registered divided clock level (high ceil(D/2), low floor(D/2))
//     - tick_o : registered one-cycle pulse once per divided period
//     - rst_no : active-low reset released after RST_TICKS ticks
//   The divisor is changed through a valid/ready handshake. An accepted value
//   is parked in a shadow register and only becomes active at the wrap cycle,
//   so every divided period runs to completion with a single divisor.
//   D=0 disables a channel (counter parked, outputs low).
//
// Optional build macro:
//   AZADI_CLKDIV_SYNC_EN - adds sync_i; a high cycle restarts every enabled
//                          channel at cnt=0 on the next edge and applies any
//                          pending divisor at that same edge.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset_ni     in   synchronous active-low reset
//   sync_i       in   phase-align strobe (AZADI_CLKDIV_SYNC_EN only)
//   div_i        in   NUM_CH*DIV_W requested divisors, channel c at [c*DIV_W +: DIV_W]
//   div_valid_i  in   NUM_CH per-channel update request
//   div_ready_o  out  NUM_CH per-channel update accept (no update pending)
//   clk_o        out  NUM_CH divided clock levels
//   tick_o       out  NUM_CH per-period pulses
//   rst_no       out  NUM_CH stretched active-low resets
// -----------------------------------------------------------------------------

// One divider channel: counter, shadow divisor, outputs and reset stretcher.
module azadi_clkdiv_ch #(
   parameter int unsigned DIV_W     = 28,
   parameter int unsigned DEF_DIV   = 5000,
   parameter int unsigned RST_TICKS = 4
) (
   input  logic             clock,
   input  logic             reset_ni,
   input  logic             sync_i,
   input  logic [DIV_W-1:0] div_i,
   input  logic             div_valid_i,
   output logic             div_ready_o,
   output logic             clk_o,
   output logic             tick_o,
   output logic             rst_no
);

   localparam int unsigned        RT_W   = $clog2(RST_TICKS + 1);
   localparam logic [RT_W-1:0]    RT_MAX = RT_W'(RST_TICKS);
   localparam logic [DIV_W-1:0]   DEF_D  = DIV_W'(DEF_DIV);
   localparam logic [DIV_W-1:0]   ONE    = DIV_W'(1);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] shadow_q, shadow_d;
   logic             pend_q, pend_d;
   logic [RT_W-1:0]  rtick_q, rtick_d;
   logic             clk_q, clk_d;
   logic             tick_q, tick_d;
   logic             rstn_q, rstn_d;

   logic             en, wrap, accept, apply;
   logic [DIV_W-1:0] last, half;

   always_comb begin
      en     = |div_q;
      last   = div_q - ONE;
      // ceil(D/2) without an extra carry bit
      half   = (div_q >> 1) + {{(DIV_W-1){1'b0}}, div_q[0]};
      wrap   = en && (cnt_q == last);
      accept = div_valid_i && !pend_q;
      // A disabled channel has no wrap, so a pending value applies right away.
      apply  = pend_q && (wrap || !en || sync_i);

      cnt_d    = cnt_q + ONE;
      if (!en || wrap || apply || sync_i) cnt_d = '0;

      div_d    = div_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      if (apply) begin
         div_d  = shadow_q;
         pend_d = 1'b0;
      end
      // accept requires !pend_q and apply requires pend_q: never both
      if (accept) begin
         shadow_d = div_i;
         pend_d   = 1'b1;
      end

      clk_d  = en && (cnt_q < half);
      tick_d = wrap;

      // Stretcher counts emitted ticks; disabled channels emit none, so hold.
      rtick_d = rtick_q;
      if (tick_q && (rtick_q != RT_MAX)) rtick_d = rtick_q + RT_W'(1);
      rstn_d  = rstn_q | (rtick_q == RT_MAX);
   end

   always_ff @(posedge clock) begin
      if (!reset_ni) begin
         cnt_q    <= '0;
         div_q    <= DEF_D;
         shadow_q <= '0;
         pend_q   <= 1'b0;
         rtick_q  <= '0;
         clk_q    <= 1'b0;
         tick_q   <= 1'b0;
         rstn_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         shadow_q <= shadow_d;
         pend_q   <= pend_d;
         rtick_q  <= rtick_d;
         clk_q    <= clk_d;
         tick_q   <= tick_d;
         rstn_q   <= rstn_d;
      end
   end

   assign div_ready_o = !pend_q;
   assign clk_o       = clk_q;
   assign tick_o      = tick_q;
   assign rst_no      = rstn_q;

endmodule

module azadi_clkdiv_rstgen #(
   parameter int unsigned NUM_CH    = 2,
   parameter int unsigned DIV_W     = 28,
   parameter int unsigned DEF_DIV   = 5000,
   parameter int unsigned RST_TICKS = 4
) (
   input  logic                    clock,
   input  logic                    reset_ni,
`ifdef AZADI_CLKDIV_SYNC_EN
   input  logic                    sync_i,
`endif
   input  logic [NUM_CH*DIV_W-1:0] div_i,
   input  logic [NUM_CH-1:0]       div_valid_i,
   output logic [NUM_CH-1:0]       div_ready_o,
   output logic [NUM_CH-1:0]       clk_o,
   output logic [NUM_CH-1:0]       tick_o,
   output logic [NUM_CH-1:0]       rst_no
);

   logic sync;
`ifdef AZADI_CLKDIV_SYNC_EN
   assign sync = sync_i;
`else
   // Without the strobe, channels are phase-aligned only by reset.
   assign sync = 1'b0;
`endif

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      azadi_clkdiv_ch #(
         .DIV_W     (DIV_W),
         .DEF_DIV   (DEF_DIV),
         .RST_TICKS (RST_TICKS)
      ) u_ch (
         .clock       (clock),
         .reset_ni    (reset_ni),
         .sync_i      (sync),
         .div_i       (div_i[c*DIV_W +: DIV_W]),
         .div_valid_i (div_valid_i[c]),
         .div_ready_o (div_ready_o[c]),
         .clk_o       (clk_o[c]),
         .tick_o      (tick_o[c]),
         .rst_no      (rst_no[c])
      );
   end

endmodule
